fpcvt_decode: RTL and testbench

Pipelined decoder from the team's 8-bit floating-point format back to 12-bit two's complement. It is the inverse of the FPCVT encoder: it takes sign S, 3-bit exponent E and 4-bit significand F, and produces D = (S ? −1 : +1) × F × 2^E. It sits downstream of the encoder, or of any block that stores FPCVT codes. It streams one code per cycle through a two-stage valid/ready pipeline and keeps a saturating count of non-canonical codes.

---
 rtl/fpcvt_decode.sv | 116 +++++++++++
 tb/tb_fpcvt_decode.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpcvt_decode.sv
// FPCVT 8-bit code (S, E[2:0], F[3:0]) to 12-bit two's-complement decoder.
// Two-stage valid/ready pipeline with a saturating count of non-canonical codes.
module fpcvt_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_S,
    input  logic [2:0]  in_E,
    input  logic [3:0]  in_F,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_D,
    output logic        out_noncanon,
    output logic [7:0]  noncanon_cnt
);

    logic        r_s1_valid;
    logic        r_s1_sign;
    logic        r_s1_noncanon;
    logic [10:0] r_s1_mag;
    logic        r_s2_valid;
    logic        r_s2_noncanon;
    logic [11:0] r_s2_data;
    logic [7:0]  r_nc_cnt;

    logic        w_s1_advance;
    logic        w_in_ready;
    logic        w_in_xfer;
    logic        w_in_noncanon;
    logic [10:0] w_in_mag;
    logic [11:0] w_s2_next;

    // Largest value is 15 << 7 = 1920, which fits in 11 bits.
    function automatic logic [10:0] shift_mag(input logic [2:0] e, input logic [3:0] f);
        return {7'd0, f} << e;
    endfunction

    function automatic logic [11:0] apply_sign(input logic s, input logic [10:0] m);
        return s ? (~{1'b0, m} + 12'd1) : {1'b0, m};
    endfunction

    // Handshake decisions and per-stage datapath values.
    always_comb begin
        w_s1_advance  = 1'b0;
        w_in_ready    = 1'b0;
        w_in_xfer     = 1'b0;
        w_in_noncanon = 1'b0;
        w_in_mag      = 11'd0;
        w_s2_next     = 12'd0;
        if (r_s1_valid) begin
            w_s1_advance = ~r_s2_valid | out_ready;
        end else begin
            w_s1_advance = 1'b0;
        end
        w_in_ready    = ~r_s1_valid | w_s1_advance;
        w_in_xfer     = in_valid & w_in_ready;
        w_in_noncanon = (in_E != 3'd0) & ~in_F[3];
        w_in_mag      = shift_mag(in_E, in_F);
        w_s2_next     = apply_sign(r_s1_sign, r_s1_mag);
    end

    // Stage 1: captures the accepted code as sign, magnitude and canonicity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_sign     <= 1'b0;
            r_s1_noncanon <= 1'b0;
            r_s1_mag      <= 11'd0;
        end else if (w_in_xfer) begin
            r_s1_valid    <= 1'b1;
            r_s1_sign     <= in_S;
            r_s1_noncanon <= w_in_noncanon;
            r_s1_mag      <= w_in_mag;
        end else if (w_s1_advance) begin
            r_s1_valid    <= 1'b0;
        end else begin
            r_s1_valid    <= r_s1_valid;
        end
    end

    // Stage 2: signed result, held until the downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid    <= 1'b0;
            r_s2_noncanon <= 1'b0;
            r_s2_data     <= 12'd0;
        end else if (w_s1_advance) begin
            r_s2_valid    <= 1'b1;
            r_s2_noncanon <= r_s1_noncanon;
            r_s2_data     <= w_s2_next;
        end else if (out_ready) begin
            r_s2_valid    <= 1'b0;
        end else begin
            r_s2_valid    <= r_s2_valid;
        end
    end

    // Non-canonical count, bumped at acceptance and pinned at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nc_cnt <= 8'd0;
        end else if (w_in_xfer && w_in_noncanon && (r_nc_cnt != 8'hFF)) begin
            r_nc_cnt <= r_nc_cnt + 8'd1;
        end else begin
            r_nc_cnt <= r_nc_cnt;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_s2_valid;
    assign out_D        = r_s2_data;
    assign out_noncanon = r_s2_noncanon;
    assign noncanon_cnt = r_nc_cnt;

endmodule

// File: tb/tb_fpcvt_decode.sv
// Bench for fpcvt_decode: an in-order expected-value queue built from the arithmetic
// definition D = (S ? -1 : 1) * F * 2^E, compared on every falling edge.
module tb_fpcvt_decode;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_S;
    logic [2:0]  in_E;
    logic [3:0]  in_F;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_D;
    logic        out_noncanon;
    logic [7:0]  noncanon_cnt;

    fpcvt_decode dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_S         (in_S),
        .in_E         (in_E),
        .in_F         (in_F),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_D        (out_D),
        .out_noncanon (out_noncanon),
        .noncanon_cnt (noncanon_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] d;
        logic        nc;
        int          acc;
    } ent_t;

    ent_t        q[$];
    logic [11:0] obs[$];
    int          cyc = 0;
    int          mcnt = 0;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [11:0] ref_d(input logic [7:0] c);
        int m;
        m = int'(c[3:0]) * (1 << c[6:4]);
        if (c[7]) m = -m;
        return m[11:0];
    endfunction

    function automatic logic ref_nc(input logic [7:0] c);
        return (c[6:4] != 3'd0) && (c[3] == 1'b0);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: at each rising edge apply the transfers the reference handshake allows.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                q.delete();
                mcnt = 0;
            end else begin
                logic ov, ir;
                logic [7:0] c;
                ov = (q.size() > 0) && (cyc >= q[0].acc + 1);
                ir = (q.size() < 2) || out_ready;
                c  = {in_S, in_E, in_F};
                if (ov && out_ready) void'(q.pop_front());
                if (in_valid && ir) begin
                    q.push_back('{d: ref_d(c), nc: ref_nc(c), acc: cyc + 1});
                    if (ref_nc(c) && mcnt < 255) mcnt++;
                end
            end
            cyc++;
        end
    end

    // Compare: every falling edge, handshake, counter, and data when valid.
    initial begin
        forever begin
            @(negedge clk);
            begin
                logic ov;
                ov = (q.size() > 0) && (cyc >= q[0].acc + 1);
                chk("in_ready", in_ready, (q.size() < 2) || (rst_n && out_ready));
                chk("out_valid", out_valid, ov);
                chk("noncanon_cnt", noncanon_cnt, mcnt[7:0]);
                if (ov) begin
                    chk("out_D", out_D, q[0].d);
                    chk("out_noncanon", out_noncanon, q[0].nc);
                end
                if (rst_n && out_valid && out_ready) obs.push_back(out_D);
            end
        end
    end

    // Present one code until accepted; rmode 0/1 fixes out_ready, 2 randomises it.
    task automatic send(input logic [7:0] c, input int rmode, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        while (!done) begin
            in_valid = 1'b1;
            {in_S, in_E, in_F} = c;
            out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
            #1;
            done = in_ready;
            @(posedge clk);
            #1;
            if (!done) begin
                waits++;
                if (waits > 100) begin
                    chk("accept_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0]  code_list[4];
    logic [11:0] lit_list[4];
    int          w;
    int          wsum;
    int          acc_n;
    logic [11:0] d0;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_S = 1'b0; in_E = 3'd0; in_F = 4'd0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_D", out_D, 12'h000);
        chk("rst_noncanon", out_noncanon, 1'b0);
        chk("rst_cnt", noncanon_cnt, 8'h00);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("model_A80", ref_d(8'b11111011), 12'hA80);
        chk("model_880", ref_d(8'b11111111), 12'h880);
        chk("model_028", ref_d(8'b00110101), 12'h028);
        chk("model_nc", ref_nc(8'b00110101), 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed stream with full throughput.
        code_list = '{8'b11111011, 8'b01111011, 8'b01111000, 8'b11111111};
        lit_list  = '{12'hA80, 12'h580, 12'h400, 12'h880};
        obs.delete(); wsum = 0;
        for (int i = 0; i < 4; i++) begin
            send(code_list[i], 1, w);
            wsum += w;
        end
        drain();
        chk("stream_waits", wsum, 0);
        chk("stream_count", obs.size(), 4);
        for (int i = 0; i < 4 && i < obs.size(); i++) chk("stream_lit", obs[i], lit_list[i]);

        // Zero and smallest magnitudes.
        code_list = '{8'b00000000, 8'b10000000, 8'b00000001, 8'b10000001};
        lit_list  = '{12'h000, 12'h000, 12'h001, 12'hFFF};
        obs.delete();
        for (int i = 0; i < 4; i++) send(code_list[i], 1, w);
        drain();
        chk("zero_count", obs.size(), 4);
        for (int i = 0; i < 4 && i < obs.size(); i++) chk("zero_lit", obs[i], lit_list[i]);

        // Exhaustive sweep with random downstream stalls.
        for (int c = 0; c < 256; c++) send(8'(c), 2, w);
        drain();

        // Backpressure: only two codes fit while the output is stalled.
        acc_n = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; out_ready = 1'b0;
            {in_S, in_E, in_F} = 8'h40 + 8'(k);
            #1;
            if (in_ready) acc_n++;
            @(posedge clk); #1;
        end
        chk("bp_accepted", acc_n, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        d0 = out_D;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("bp_stable_D", out_D, d0);
        chk("bp_valid", out_valid, 1'b1);
        drain();

        // Reset while both stages hold codes.
        send(8'b00110101, 0, w);
        send(8'b00110101, 0, w);
        rst_n = 1'b0;
        q.delete(); mcnt = 0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_cnt", noncanon_cnt, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        obs.delete();
        send(8'b01111000, 1, w);
        drain();
        chk("postrst_count", obs.size(), 1);
        if (obs.size() > 0) chk("postrst_D", obs[0], 12'h400);

        // Non-canonical flood drives the counter into saturation.
        for (int i = 0; i < 300; i++) send(8'b00110101, 2, w);
        drain();
        chk("nc_saturated", noncanon_cnt, 8'hFF);
        chk("model_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
